// File: rtl/dbus_input_port.sv
// dbus_input_port
// Memory-mapped input port responder on the data memory bus. Raw board inputs
// pass through a two-flop synchronizer and a per-bit debouncer; the debounced
// levels, sticky rising-edge flags and an interrupt mask are readable over the
// bus. o_RdData is zero whenever the block is not addressed so the top level
// can OR it with the data memory read data.
//
// Register map (byte offsets from BASE_ADDR, i_Addr[1:0] ignored):
//   +0  STATE  read-only debounced levels
//   +4  EDGE   rising-edge flags, write-1-to-clear
//   +8  MASK   interrupt mask, read/write
//   +12 FALL   falling-edge flags, write-1-to-clear (reads 0 when disabled)
//
// Optional feature: define INPORT_FALL_EDGE_EN to build the FALL register and
// include it in the interrupt term. Without it, +12 reads 0, ignores writes,
// and no FALL flops exist.
module dbus_input_port #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 10'h0204,
  parameter int                    IN_WIDTH        = 6,
  parameter int                    DEBOUNCE_CYCLES = 500000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  logic                  i_WrEnable,
  input  logic [DATA_WIDTH-1:0] i_WrData,
  output logic [DATA_WIDTH-1:0] o_RdData,
  output logic                  o_Hit,
  input  logic [IN_WIDTH-1:0]   i_Inputs,
  output logic                  o_Irq
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1, after which it is reset.
  localparam int                    CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-3:0] BASE_WORD = BASE_ADDR[ADDR_WIDTH-1:2];

  localparam logic [1:0] OFF_STATE = 2'd0;
  localparam logic [1:0] OFF_EDGE  = 2'd1;
  localparam logic [1:0] OFF_MASK  = 2'd2;
  localparam logic [1:0] OFF_FALL  = 2'd3;

  // ------------------------------------------------------------------------
  // Address decode: the block spans four consecutive words from BASE_ADDR.
  // The word offset is computed modulo the address space; any address below
  // the base wraps to a large offset and therefore misses.
  // ------------------------------------------------------------------------
  logic [ADDR_WIDTH-3:0] w_word_off;
  logic [1:0]            w_reg_sel;
  logic                  w_hit;
  logic                  w_wr;
  logic                  w_wr_edge;
  logic                  w_wr_mask;
  logic [IN_WIDTH-1:0]   w_wdata;

  assign w_word_off = i_Addr[ADDR_WIDTH-1:2] - BASE_WORD;
  assign w_hit      = (w_word_off[ADDR_WIDTH-3:2] == '0);
  assign w_reg_sel  = w_word_off[1:0];
  assign w_wr       = i_WrEnable & w_hit;
  assign w_wr_edge  = w_wr & (w_reg_sel == OFF_EDGE);
  assign w_wr_mask  = w_wr & (w_reg_sel == OFF_MASK);
  assign w_wdata    = i_WrData[IN_WIDTH-1:0];
  assign o_Hit      = w_hit;

  // Byte-lane bits of the address and data bits above IN_WIDTH are unused.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, i_Addr[1:0], i_WrData};

  // ------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous board inputs.
  // ------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] r_sync1;
  logic [IN_WIDTH-1:0] r_sync2;

  // Synchronizer chain: raw -> s1 -> s2.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_Inputs;
      r_sync2 <= r_sync1;
    end
  end

  // ------------------------------------------------------------------------
  // Per-bit debouncer. Each bit counts consecutive cycles where the
  // synchronized value differs from the accepted level; any return to the
  // accepted level (a bounce) restarts the count. On the cycle the count
  // reaches its last value while still differing, the new level is accepted.
  // ------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] r_stable;
  logic [IN_WIDTH-1:0] w_stable_next;

  generate
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             w_differ;
      logic             w_accept;

      assign w_differ = r_sync2[gi] ^ r_stable[gi];
      assign w_accept = w_differ && (r_cnt == CNT_LAST);
      assign w_stable_next[gi] = w_accept ? r_sync2[gi] : r_stable[gi];

      // Stability counter: runs while the input differs, clears on a bounce
      // or when the change is accepted, so it never wraps.
      always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
          r_cnt <= '0;
        end else if (!w_differ || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Accepted (debounced) input levels.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_stable <= '0;
    end else begin
      r_stable <= w_stable_next;
    end
  end

  // ------------------------------------------------------------------------
  // Edge capture and interrupt mask.
  // ------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] w_rise;
  logic [IN_WIDTH-1:0] r_edge;
  logic [IN_WIDTH-1:0] r_mask;

  // A rise is flagged on the same edge the debounced level goes 0->1.
  assign w_rise = w_stable_next & ~r_stable;

  // Sticky rise flags; a new rise in the clearing cycle keeps the flag set.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_edge <= '0;
    end else if (w_wr_edge) begin
      r_edge <= (r_edge & ~w_wdata) | w_rise;
    end else begin
      r_edge <= r_edge | w_rise;
    end
  end

  // Interrupt mask, plain read/write.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_mask <= '0;
    end else if (w_wr_mask) begin
      r_mask <= w_wdata;
    end
  end

`ifdef INPORT_FALL_EDGE_EN
  logic [IN_WIDTH-1:0] w_fall;
  logic [IN_WIDTH-1:0] r_fall;
  logic                w_wr_fall;

  assign w_fall    = r_stable & ~w_stable_next;
  assign w_wr_fall = w_wr & (w_reg_sel == OFF_FALL);

  // Sticky fall flags with the same set-beats-clear rule as the rise flags.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_fall <= '0;
    end else if (w_wr_fall) begin
      r_fall <= (r_fall & ~w_wdata) | w_fall;
    end else begin
      r_fall <= r_fall | w_fall;
    end
  end

  // Interrupt is formed from flops only so bus activity cannot glitch it.
  assign o_Irq = |((r_edge | r_fall) & r_mask);
`else
  // Interrupt is formed from flops only so bus activity cannot glitch it.
  assign o_Irq = |(r_edge & r_mask);
`endif

  // ------------------------------------------------------------------------
  // Zero-latency read mux; drives zero when the block is not addressed.
  // ------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] w_rd_bits;

  // Register select and zero-extension onto the bus.
  always_comb begin
    w_rd_bits = '0;
    o_RdData  = '0;
    case (w_reg_sel)
      OFF_STATE: w_rd_bits = r_stable;
      OFF_EDGE:  w_rd_bits = r_edge;
      OFF_MASK:  w_rd_bits = r_mask;
`ifdef INPORT_FALL_EDGE_EN
      OFF_FALL:  w_rd_bits = r_fall;
`else
      OFF_FALL:  w_rd_bits = '0;
`endif
      default:   w_rd_bits = '0;
    endcase
    if (w_hit) begin
      o_RdData[IN_WIDTH-1:0] = w_rd_bits;
    end
  end

endmodule

// File: tb/tb_dbus_input_port.sv
// tb_dbus_input_port
// Scoreboard bench for dbus_input_port with DEBOUNCE_CYCLES=4. The stimulus
// process keeps a behavioural model (input history window, flag sets) and
// pushes the expected read response for every bus read; a separate monitor
// pops and compares while the read address is presented.
module tb_dbus_input_port;

  localparam int D      = 4;
  localparam int BASE_I = 'h204;

  logic        i_Clock;
  logic        i_Reset;
  logic [9:0]  i_Addr;
  logic        i_WrEnable;
  logic [31:0] i_WrData;
  logic [31:0] o_RdData;
  logic        o_Hit;
  logic [5:0]  i_Inputs;
  logic        o_Irq;

  logic        rd_req;

  dbus_input_port #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (10),
    .BASE_ADDR       (10'h0204),
    .IN_WIDTH        (6),
    .DEBOUNCE_CYCLES (D)
  ) u_dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Addr     (i_Addr),
    .i_WrEnable (i_WrEnable),
    .i_WrData   (i_WrData),
    .o_RdData   (o_RdData),
    .o_Hit      (o_Hit),
    .i_Inputs   (i_Inputs),
    .o_Irq      (o_Irq)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic        irq;
    logic [9:0]  addr;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // ---------------- behavioural model ----------------
  // Debounced level of a bit flips when the last D synchronized samples
  // (raw input delayed by two edges) all disagree with it.
  logic [5:0] m_stable, m_edge, m_mask, m_fall;
  logic [5:0] m_hist [0:D+1];   // m_hist[0] = raw sampled at previous edge

  function automatic int widx(input logic [9:0] a);
    return (int'(a) >> 2) - (BASE_I >> 2);
  endfunction

  task automatic model_reset();
    m_stable = '0;
    m_edge   = '0;
    m_mask   = '0;
    m_fall   = '0;
    for (int j = 0; j <= D + 1; j++) m_hist[j] = '0;
  endtask

  // Applies the effect of the clock edge that has just occurred.
  task automatic model_step();
    logic [5:0] ns;
    logic [5:0] rise;
    logic [5:0] fl;
    int         w;
    ns = m_stable;
    for (int b = 0; b < 6; b++) begin
      bit all_other;
      all_other = 1'b1;
      for (int j = 1; j <= D; j++)
        if (m_hist[j][b] == m_stable[b]) all_other = 1'b0;
      if (all_other) ns[b] = ~m_stable[b];
    end
    rise = ns & ~m_stable;
    fl   = m_stable & ~ns;
    w    = widx(i_Addr);
    if (i_WrEnable && w == 1) m_edge = m_edge & ~i_WrData[5:0];
    m_edge = m_edge | rise;
    if (i_WrEnable && w == 2) m_mask = i_WrData[5:0];
`ifdef INPORT_FALL_EDGE_EN
    if (i_WrEnable && w == 3) m_fall = m_fall & ~i_WrData[5:0];
    m_fall = m_fall | fl;
`else
    if (fl != 6'd0) m_fall = '0;
`endif
    m_stable = ns;
    for (int j = D + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = i_Inputs;
  endtask

  function automatic logic [31:0] model_rd(input logic [9:0] a);
    logic [31:0] r;
    r = '0;
    case (widx(a))
      0: r[5:0] = m_stable;
      1: r[5:0] = m_edge;
      2: r[5:0] = m_mask;
      3: r[5:0] = m_fall;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic model_hit(input logic [9:0] a);
    return (widx(a) >= 0) && (widx(a) < 4);
  endfunction

  function automatic logic model_irq();
    return |((m_edge | m_fall) & m_mask);
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic tick();
    @(negedge i_Clock);
    if (i_Reset) model_step();
  endtask

  task automatic do_idle();
    tick();
    i_WrEnable = 1'b0;
    rd_req     = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    tick();
    i_Addr     = a;
    i_WrData   = d;
    i_WrEnable = 1'b1;
    rd_req     = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input string tag);
    exp_t e;
    tick();
    i_Addr     = a;
    i_WrEnable = 1'b0;
    i_WrData   = $urandom;
    e.data = model_rd(a);
    e.hit  = model_hit(a);
    e.irq  = model_irq();
    e.addr = a;
    e.tag  = tag;
    sb_q.push_back(e);
    rd_req = 1'b1;
  endtask

  task automatic do_check(input logic [9:0] a, input logic [31:0] d,
                          input logic hit, input logic irq, input string tag);
    exp_t e;
    tick();
    i_Addr     = a;
    i_WrEnable = 1'b0;
    e.data = d;
    e.hit  = hit;
    e.irq  = irq;
    e.addr = a;
    e.tag  = tag;
    sb_q.push_back(e);
    rd_req = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    tick();
    i_Reset    = 1'b0;
    i_WrEnable = 1'b0;
    rd_req     = 1'b0;
    model_reset();
    repeat (cycles) @(negedge i_Clock);
    i_Reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_Clock) begin
    exp_t e;
    #2;
    if (rd_req) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty addr=%h got data=%h but no expected entry", i_Addr, o_RdData);
      end else begin
        e = sb_q.pop_front();
        if (o_RdData !== e.data || o_Hit !== e.hit || o_Irq !== e.irq) begin
          n_err++;
          $display("FAIL %s addr=%h got data=%h hit=%b irq=%b want data=%h hit=%b irq=%b",
                   e.tag, e.addr, o_RdData, o_Hit, o_Irq, e.data, e.hit, e.irq);
        end else begin
          $display("rd %s addr=%h data=%h hit=%b irq=%b", e.tag, e.addr, o_RdData, o_Hit, o_Irq);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    i_Reset    = 1'b0;
    i_Inputs   = '0;
    i_Addr     = '0;
    i_WrEnable = 1'b0;
    i_WrData   = '0;
    rd_req     = 1'b0;
    model_reset();
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b1;

    // Reset state and decode
    do_check(10'h204, 32'd0, 1'b1, 1'b0, "t1_state");
    do_check(10'h208, 32'd0, 1'b1, 1'b0, "t1_edge");
    do_check(10'h20C, 32'd0, 1'b1, 1'b0, "t1_mask");
    do_check(10'h210, 32'd0, 1'b1, 1'b0, "t1_fall");
    do_check(10'h300, 32'd0, 1'b0, 1'b0, "t1_unmapped");

    // Three-cycle pulse is rejected
    do_idle();
    i_Inputs = 6'h01;
    repeat (3) do_idle();
    i_Inputs = 6'h00;
    repeat (8) do_read(10'h204, "t3_settle");
    do_check(10'h204, 32'd0, 1'b1, 1'b0, "t3_state");
    do_check(10'h208, 32'd0, 1'b1, 1'b0, "t3_edge");

    // Held change accepted on the sixth edge, not the fifth
    do_read(10'h204, "t2_pre");
    i_Inputs = 6'h01;
    repeat (4) do_read(10'h204, "t2_wait");
    do_check(10'h204, 32'd0, 1'b1, 1'b0, "t2_state_at5");
    do_check(10'h204, 32'd1, 1'b1, 1'b0, "t2_state_at6");
    do_check(10'h208, 32'd1, 1'b1, 1'b0, "t2_edge");

    // Mask, interrupt, write-1-clear, set beats clear
    do_write(10'h20C, 32'd1);
    do_check(10'h208, 32'd1, 1'b1, 1'b1, "t4_irq_set");
    do_write(10'h208, 32'd1);
    do_check(10'h208, 32'd0, 1'b1, 1'b0, "t4_irq_clear");
    do_read(10'h204, "t4_pre");
    i_Inputs = 6'h03;
    repeat (4) do_read(10'h204, "t4_wait");
    do_write(10'h208, 32'h3);
    do_check(10'h208, 32'h2, 1'b1, 1'b0, "t4_clear_vs_rise");
    do_check(10'h204, 32'h3, 1'b1, 1'b0, "t4_state");

    // Reset in the middle of a debounce
    do_read(10'h204, "t5_pre");
    i_Inputs = 6'h07;
    repeat (3) do_read(10'h204, "t5_wait");
    do_reset(2);
    repeat (4) do_read(10'h204, "t5_after");
    do_check(10'h204, 32'h0, 1'b1, 1'b0, "t5_state_at5");
    do_check(10'h204, 32'h7, 1'b1, 1'b0, "t5_state_at6");

    // Fall register / reserved offset
    do_write(10'h208, 32'hFFFF_FFFF);
    do_read(10'h204, "t6_pre");
    i_Inputs = 6'h00;
    repeat (8) do_read(10'h210, "t6_wait");
`ifdef INPORT_FALL_EDGE_EN
    do_check(10'h210, 32'h7, 1'b1, 1'b0, "t6_fall");
    do_write(10'h20C, 32'h4);
    do_check(10'h210, 32'h7, 1'b1, 1'b1, "t6_fall_irq");
    do_write(10'h210, 32'hFFFF_FFFF);
    do_check(10'h210, 32'h0, 1'b1, 1'b0, "t6_fall_clear");
`else
    do_write(10'h210, 32'hFFFF_FFFF);
    do_check(10'h210, 32'h0, 1'b1, 1'b0, "t6_fall_absent");
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 299);
      if (r < 150) begin
        do_read(10'(10'h1F8 + 4 * $urandom_range(0, 9) + $urandom_range(0, 3)), "rand_rd");
      end else if (r < 240) begin
        logic [31:0] d;
        d = ($urandom_range(0, 1) == 0) ? (32'd1 << $urandom_range(0, 7)) : $urandom;
        do_write(10'(BASE_I + 4 * $urandom_range(0, 3) + $urandom_range(0, 3)), d);
      end else if (r < 298) begin
        do_idle();
      end else begin
        do_reset($urandom_range(1, 3));
      end
      if ($urandom_range(0, 15) == 0) i_Inputs = i_Inputs ^ 6'($urandom_range(1, 63));
    end

    do_idle();
    do_idle();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d pending entries want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
